// File: rtl/fetch_stage_ctrl.sv
// Fetch stage controller: owns the PC and the IF/ID pipeline register,
// obeys hazard-unit write enables, applies ID-resolved redirects, and
// keeps saturating stall/flush performance counters.
module fetch_stage_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCWrite,
    input  logic            IFIDWrite,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ready,
    output logic [XLEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc4,
    output logic            ifid_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   ifid_instr_d;
    logic [XLEN-1:0]   ifid_pc4_d;
    logic              ifid_valid_d;
    logic [CNT_W-1:0]  stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_d;

    logic              redirect;
    logic              redirect_applied;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   pc_plus4;
    logic              fetch_done;

    // The fetch address is the PC register itself.
    assign imem_addr = pc_q;

    // Next-state, PC, IF/ID and counter logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr;
        ifid_pc4_d   = ifid_pc4;
        ifid_valid_d = ifid_valid;
        stall_cnt_d  = stall_cnt;
        flush_cnt_d  = flush_cnt;

        redirect         = jump | branch_taken;
        target           = jump ? jump_target : branch_target;
        // A redirect seen while PC is frozen is re-presented by ID later.
        redirect_applied = redirect & PCWrite;
        pc_plus4         = pc_q + XLEN'(4);
        fetch_done       = imem_ready && (state_q != BOOT);

        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (!imem_ready && !redirect_applied) state_d = WAIT;
            end
            WAIT: begin
                if (imem_ready || redirect_applied) state_d = RUN;
            end
            default: state_d = BOOT;
        endcase

        if (!PCWrite) begin
            pc_d = pc_q;
        end else if (redirect) begin
            pc_d = target;
        end else if (fetch_done) begin
            pc_d = pc_plus4;
        end

        if (!IFIDWrite) begin
            ifid_instr_d = ifid_instr;
        end else if (redirect_applied) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (fetch_done) begin
            ifid_instr_d = imem_rdata;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
        end else begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end

        if (!PCWrite && (stall_cnt != '1)) begin
            stall_cnt_d = stall_cnt + CNT_W'(1);
        end
        if (redirect_applied && (flush_cnt != '1)) begin
            flush_cnt_d = flush_cnt + CNT_W'(1);
        end
    end

    // State, PC, IF/ID and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= '0;
            ifid_valid <= 1'b0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ifid_instr <= ifid_instr_d;
            ifid_pc4   <= ifid_pc4_d;
            ifid_valid <= ifid_valid_d;
            stall_cnt  <= stall_cnt_d;
            flush_cnt  <= flush_cnt_d;
        end
    end

endmodule
